// File: rtl/dmem_pkg.sv
// Shared types and constants for the slow data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_LATENCY = 2;
    localparam int MAX_LATENCY = 16;

    // Wide enough to hold LATENCY-2 for every legal latency, with headroom.
    localparam int CNT_W = 5;

    function automatic bit latency_ok(input int lat);
        return (lat >= 1) && (lat <= MAX_LATENCY);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Storage for the responder: synchronous write, combinational read, zero at time zero.
module dmem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    // Contents survive reset on purpose; only power-up zeroes them.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle, back-pressurable data-memory responder for the memory stage.
// Define DMEM_B2B_EN to accept a new request in the same cycle as the response handshake.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = 256,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata
);

    if (!latency_ok(LATENCY) || DEPTH != (2 ** ADDR_W)) begin : g_bad_param
        $error("dmem_responder: illegal LATENCY or DEPTH/ADDR_W combination");
    end

    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              write_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;

    logic              accept;
    logic              access_direct;
    logic              access_wait;
    logic              acc_write;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] resp_data;

`ifdef DMEM_B2B_EN
    assign req_ready = (state_reg == IDLE) || ((state_reg == RESP) && rsp_ready);
`else
    assign req_ready = (state_reg == IDLE);
`endif

    assign accept        = req_valid && req_ready;
    // With a single-cycle latency the access happens on the handshake edge itself,
    // so the array must see the live request rather than the latched copy.
    assign access_direct = (LATENCY == 1) && accept;
    assign access_wait   = (state_reg == WAIT) && (cnt_reg == '0);

    assign acc_write = access_direct ? req_write : write_reg;
    assign acc_addr  = access_direct ? req_addr  : addr_reg;
    assign acc_wdata = access_direct ? req_wdata : wdata_reg;
    assign resp_data = acc_write ? acc_wdata : mem_rdata;

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    ((access_direct || access_wait) && acc_write),
        .addr  (acc_addr),
        .wdata (acc_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            write_reg <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state_reg)
                IDLE: ;
                WAIT: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_write <= acc_write;
                        rsp_rdata <= resp_data;
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // A new request overrides the RESP->IDLE step when back-to-back is enabled.
            if (accept) begin
                write_reg <= req_write;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
                if (LATENCY == 1) begin
                    rsp_valid <= 1'b1;
                    rsp_write <= req_write;
                    rsp_rdata <= resp_data;
                    state_reg <= RESP;
                end else begin
                    cnt_reg   <= CNT_INIT;
                    state_reg <= WAIT;
                end
            end
        end
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's memory stage: accepts one load/store request at a time over a valid/ready channel.
- Performs the access on an internal DEPTH x DATA_W array after a programmable latency.
- Returns a response over a second valid/ready channel.
- Models a slow data memory, so the memory stage can be exercised against multi-cycle, back-pressured memory instead of a single-cycle array.

Parameters:
- ADDR_W, 8, request address width
- DATA_W, 8, data width
- DEPTH, 256, array entries; must equal 2**ADDR_W
- LATENCY, 2, cycles from request handshake to rsp_valid; legal range 1..16

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  effective address (ALU result)
- req_wdata  in  DATA_W  store data
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts response
- rsp_write  out  1  echo of req_write for the response
- rsp_rdata  out  DATA_W  load data; for a store, the data written

Behaviour:
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_write=0, rsp_rdata=0, latency counter=0.
- Array contents are not cleared by reset. All entries are zero at time zero.
- FSM states and transitions:
  - IDLE: req_ready=1. When req_valid&req_ready, latch write/addr/wdata.
    - If LATENCY==1: perform the access on that edge and go to RESP.
    - Otherwise: load cnt=LATENCY-2 and go to WAIT.
  - WAIT: req_ready=0.
    - cnt!=0: decrement.
    - cnt==0: perform the access and go to RESP.
  - RESP: rsp_valid=1, req_ready=0. When rsp_valid&rsp_ready, clear rsp_valid and go to IDLE.
- Access definition:
  - Store writes the array at the latched address, sets rsp_rdata=wdata and rsp_write=1.
  - Load sets rsp_rdata=array[addr] and rsp_write=0.
- Timing: handshake in cycle T gives rsp_valid high in cycle T+LATENCY exactly.
- rsp_rdata and rsp_write are stable while rsp_valid=1 and rsp_ready=0, for any stall length.
- Throughput without the option: one request per LATENCY+1 cycles minimum. req_ready returns to 1 the cycle after the response handshake.
- Inputs sampled only at the handshake edge. Later changes to req_* while busy are ignored.
- Load after store to the same address returns the stored value; the store commits before the next request can be accepted.
- Address wrap: ADDR_W bits index the array directly. No out-of-range case exists.
- Reset mid-operation (WAIT or RESP): abort and return to the reset values.
  - A store not yet committed is dropped.
  - A store already committed stays in the array.

Optional Feature:
- Macro: DMEM_B2B_EN
- Defined: in RESP, req_ready = rsp_ready. A request and the response handshake in the same cycle are both accepted; the new request enters WAIT (or RESP when LATENCY==1) directly, with no IDLE bubble. Throughput becomes one per LATENCY cycles when rsp_ready is held high.
- Not defined: req_ready=0 in RESP, as described above.

Decomposition:
- Package dmem_pkg: state enum (IDLE, WAIT, RESP), default width/latency constants, and the counter width derived for LATENCY up to 16 (5 bits).
- Sub-module dmem_array: storage only, with synchronous write, combinational read, zero init. The FSM, counter and response registers stay in dmem_responder.

Test Plan:
- Reset, then store addr 0x10 data 0xA5 with LATENCY=2 and rsp_ready=1 -> rsp_valid exactly 2 cycles after handshake, rsp_write=1, rsp_rdata=0xA5; req_ready low during WAIT/RESP.
- Load 0x10 after that store -> rsp_rdata=0xA5, rsp_write=0. Load untouched 0xFF -> 0x00.
- Load with rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata held stable, req_ready=0 throughout; response completes on the first rsp_ready=1.
- LATENCY=1: store 0x3C to 0x00 then load 0x00 -> each response 1 cycle after handshake; load returns 0x3C.
- Assert reset during WAIT of a store to 0x20 (LATENCY=4) -> outputs return to reset values immediately; a later load of 0x20 returns 0x00.
- With DMEM_B2B_EN, rsp_ready=1, four loads back-to-back -> handshakes every LATENCY cycles, no idle bubble; without the macro, LATENCY+1 spacing.
